// File: rtl/tlul_host_arb_pkg.sv
// Shared TL-UL types, widths and helpers for the M:1 host arbiter.
package tlul_host_arb_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbLock = 1'b1
  } arb_state_e;

  // Slot reached by stepping off positions from base in a ring of m entries.
  function automatic int unsigned rr_slot(int unsigned base, int unsigned off, int unsigned m);
    return (base + off) % m;
  endfunction

endpackage

// File: rtl/tlul_host_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr, modulo M.
module tlul_host_arb_rr
  import tlul_host_arb_pkg::*;
#(
  parameter  int M    = 3,
  localparam int IdxW = $clog2(M)
) (
  input  logic [M-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [M-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx,
  output logic            valid
);

  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < M; k++) begin
      idx = rr_slot(32'(ptr), k, M);
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// M:1 TL-UL host arbiter: round-robin grant with per-host outstanding limits,
// host index carried in the top bits of a_source so responses route statelessly.
module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter  int M              = 3,
  parameter  int MaxOutstanding = 4,
  localparam int IdxW           = $clog2(M)
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i [M],
  output tl_d2h_t tl_h_o [M],
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic [M-1:0] gnt_o,
  output logic    src_err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int LowW = TL_AIW - IdxW;

  arb_state_e      state;
  logic [IdxW-1:0] ptr, lock_idx, rr_idx, gnt_idx, d_idx;
  logic [CntW-1:0] cnt [M];
  logic [M-1:0]    eligible, rr_gnt;
  logic            rr_valid, gnt_valid, a_hs, d_hs, bad_idx, tag_err;
  tl_h2d_t         host_req, a_chan;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      eligible[i] = tl_h_i[i].a_valid && (cnt[i] < CntW'(MaxOutstanding));
    end
  end

  tlul_host_arb_rr #(.M(M)) u_rr (
    .req     (eligible),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .valid   (rr_valid)
  );

  // While locked the registered index wins so the A channel cannot switch hosts mid-beat.
  always_comb begin
    gnt_idx   = (state == ArbLock) ? lock_idx : rr_idx;
    gnt_valid = rst_ni && ((state == ArbLock) || rr_valid);
    host_req  = tl_h_i[gnt_idx];
    gnt_o     = '0;
    if (gnt_valid) begin
      gnt_o = (state == ArbLock) ? M'(1) << lock_idx : rr_gnt;
    end
  end

  assign d_idx   = tl_d_i.d_source[TL_AIW-1 -: IdxW];
  assign bad_idx = (int'(d_idx) >= M);
  assign tag_err = (host_req.a_source[TL_AIW-1 -: IdxW] != '0);

  always_comb begin
    tl_d_o = '0;
    if (gnt_valid) begin
      tl_d_o          = host_req;
      tl_d_o.a_source = {gnt_idx, host_req.a_source[LowW-1:0]};
    end
    tl_d_o.d_ready = bad_idx ? 1'b1 : tl_h_i[d_idx].d_ready;
  end

  assign a_hs = tl_d_o.a_valid && tl_d_i.a_ready;
  assign d_hs = tl_d_i.d_valid && tl_d_o.d_ready;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      tl_h_o[i] = '0;
      if (!bad_idx && d_idx == IdxW'(i)) begin
        tl_h_o[i] = tl_d_i;
        tl_h_o[i].d_source[TL_AIW-1 -: IdxW] = '0;
      end
      tl_h_o[i].a_ready = gnt_o[i] && tl_d_i.a_ready;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ArbIdle;
      lock_idx  <= '0;
      ptr       <= '0;
      src_err_o <= 1'b0;
      for (int i = 0; i < M; i++) cnt[i] <= '0;
    end else begin
      src_err_o <= (a_hs && tag_err) || (tl_d_i.d_valid && bad_idx);
      case (state)
        ArbIdle: if (gnt_valid && !tl_d_i.a_ready) begin
          state    <= ArbLock;
          lock_idx <= gnt_idx;
        end
        ArbLock: if (a_hs) state <= ArbIdle;
        default: state <= ArbIdle;
      endcase
      if (a_hs) ptr <= IdxW'(rr_slot(32'(gnt_idx), 1, M));
      // A simultaneous issue and retire for one host cancel out.
      for (int i = 0; i < M; i++) begin
        if ((a_hs && gnt_idx == IdxW'(i)) && !(d_hs && !bad_idx && d_idx == IdxW'(i))) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (!(a_hs && gnt_idx == IdxW'(i)) && (d_hs && !bad_idx && d_idx == IdxW'(i))) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    a_chan         = tl_d_o;
    a_chan.d_ready = 1'b0;
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state == ArbLock) |-> $stable(a_chan));

  for (genvar g = 0; g < M; g++) begin : g_cnt_chk
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt[g] <= CntW'(MaxOutstanding));
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (d_hs && !bad_idx && d_idx == IdxW'(g)) |-> (cnt[g] != '0));
  end

endmodule
